// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit period and the
// receive/transmit state encoding.
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_CLKS_PER_BIT = 5208;

  // ST_ prefix keeps the literals clear of the receiver's DATA port.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input.
// RST_VAL sets the value both flops take while reset is asserted.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic ASYNC_IN,
  output logic SYNC_OUT
);

  logic meta;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta     <= RST_VAL;
      SYNC_OUT <= RST_VAL;
    end else begin
      meta     <= ASYNC_IN;
      SYNC_OUT <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. Oversamples RX_LINE with CLK, verifies the
// start bit at its mid-point and samples each later bit one period apart.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   RX_LINE,
  output logic [UART_DATA_W-1:0] DATA,
  output logic                   VALID,
  output logic                   FRAME_ERR,
  output logic                   BUSY,
  output uart_state_e            DBG_STATE
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  // Output handshake: VALID is a single-cycle strobe with no ready/hold;
  // DATA is stable from that cycle until the next good frame.

  logic line_sync;
  logic line_prev;

  uart_state_e            state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [2:0]             idx, idx_d;
  logic [UART_DATA_W-1:0] shreg, shreg_d;
  logic [UART_DATA_W-1:0] data_d;
  logic                   valid_d;
  logic                   ferr_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .ASYNC_IN (RX_LINE),
    .SYNC_OUT (line_sync)
  );

  // Previous-value flop resets high so leaving reset never looks like an edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) line_prev <= 1'b1;
    else        line_prev <= line_sync;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      DATA      <= '0;
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
      shreg     <= shreg_d;
      DATA      <= data_d;
      VALID     <= valid_d;
      FRAME_ERR <= ferr_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    shreg_d = shreg;
    data_d  = DATA;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_d = '0;
        if (!line_sync && line_prev) state_d = ST_START;
      end
      ST_START: begin
        if (cnt == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A line already back high at mid-start was a glitch.
          state_d = line_sync ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_d          = '0;
          shreg_d[idx]   = line_sync;
          idx_d          = idx + 3'd1;
          if (idx == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (line_sync) begin
            data_d  = shreg;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign BUSY      = (state != ST_IDLE);
  assign DBG_STATE = state;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: directed scenarios
// plus a randomized stream against a frame-level timing/data model.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic        CLK;
  logic        RST_N;
  logic        RX_LINE;
  logic [7:0]  DATA;
  logic        VALID;
  logic        FRAME_ERR;
  logic        BUSY;
  uart_state_e DBG_STATE;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .RX_LINE   (RX_LINE),
    .DATA      (DATA),
    .VALID     (VALID),
    .FRAME_ERR (FRAME_ERR),
    .BUSY      (BUSY),
    .DBG_STATE (DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- observation queues ----------------
  int unsigned vld_t_q[$];
  logic [7:0]  vld_d_q[$];
  int unsigned ferr_t_q[$];
  int unsigned rise_q[$];
  int unsigned fall_q[$];
  logic        busy_prev = 1'b0;

  always @(negedge CLK) begin
    if (VALID) begin
      vld_t_q.push_back(cyc);
      vld_d_q.push_back(DATA);
    end
    if (FRAME_ERR) ferr_t_q.push_back(cyc);
    if (BUSY && !busy_prev) rise_q.push_back(cyc);
    if (!BUSY && busy_prev) fall_q.push_back(cyc);
    busy_prev = BUSY;
  end

  task automatic clear_mon();
    vld_t_q.delete();
    vld_d_q.delete();
    ferr_t_q.delete();
    rise_q.delete();
    fall_q.delete();
  endtask

  // ---------------- reference model ----------------
  // Stop-bit sample edge counted from the first edge the line is seen low.
  function automatic int unsigned stop_edge(input int unsigned e0);
    return e0 + 2 + HALF + 9 * CPB;
  endfunction

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic drive(input int cycles, input logic lvl);
    RX_LINE = lvl;
    repeat (cycles) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_lvl,
                            output int unsigned e0);
    e0 = cyc + 1;
    drive(CPB, 1'b0);
    for (int i = 0; i < 8; i++) drive(CPB, b[i]);
    drive(CPB, stop_lvl);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST_N   = 1'b0;
    RX_LINE = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++; if (DATA !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %0h expected 0", DATA); end
    n_cmp++; if (VALID !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b expected 0", VALID); end
    n_cmp++; if (FRAME_ERR !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %0b expected 0", FRAME_ERR); end
    n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b expected 0", BUSY); end
    RST_N = 1'b1;
    clear_mon();
    drive(10, 1'b1);
    n_cmp++; if (rise_q.size() !== 0) begin n_bad++; $display("FAIL reset_false_start: got %0d busy rises expected 0", rise_q.size()); end
  endtask

  task automatic test_single();
    int unsigned e0;
    clear_mon();
    send_frame(8'hA5, 1'b1, e0);
    drive(10, 1'b1);
    n_cmp++; if (vld_t_q.size() !== 1) begin n_bad++; $display("FAIL single_valid_count: got %0d expected 1", vld_t_q.size()); end
    n_cmp++; if (vld_t_q[0] !== stop_edge(e0)) begin n_bad++; $display("FAIL single_valid_time: got %0d expected %0d", vld_t_q[0], stop_edge(e0)); end
    n_cmp++; if (vld_d_q[0] !== 8'hA5) begin n_bad++; $display("FAIL single_pulse_data: got %0h expected a5", vld_d_q[0]); end
    n_cmp++; if (DATA !== 8'hA5) begin n_bad++; $display("FAIL single_data_hold: got %0h expected a5", DATA); end
    n_cmp++; if (ferr_t_q.size() !== 0) begin n_bad++; $display("FAIL single_ferr: got %0d pulses expected 0", ferr_t_q.size()); end
    n_cmp++; if (rise_q.size() !== 1 || rise_q[0] !== e0 + 2) begin n_bad++; $display("FAIL single_busy_rise: got %0d expected %0d", rise_q[0], e0 + 2); end
    n_cmp++; if (fall_q.size() !== 1 || fall_q[0] !== stop_edge(e0)) begin n_bad++; $display("FAIL single_busy_fall: got %0d expected %0d", fall_q[0], stop_edge(e0)); end
  endtask

  task automatic test_back_to_back();
    int unsigned ea, eb;
    clear_mon();
    send_frame(8'h00, 1'b1, ea);
    send_frame(8'hFF, 1'b1, eb);
    drive(10, 1'b1);
    n_cmp++; if (vld_t_q.size() !== 2) begin n_bad++; $display("FAIL b2b_count: got %0d expected 2", vld_t_q.size()); end
    n_cmp++; if (vld_d_q[0] !== 8'h00) begin n_bad++; $display("FAIL b2b_data0: got %0h expected 0", vld_d_q[0]); end
    n_cmp++; if (vld_d_q[1] !== 8'hFF) begin n_bad++; $display("FAIL b2b_data1: got %0h expected ff", vld_d_q[1]); end
    n_cmp++; if (vld_t_q[0] !== stop_edge(ea)) begin n_bad++; $display("FAIL b2b_time0: got %0d expected %0d", vld_t_q[0], stop_edge(ea)); end
    n_cmp++; if (vld_t_q[1] - vld_t_q[0] !== 160) begin n_bad++; $display("FAIL b2b_spacing: got %0d expected 160", vld_t_q[1] - vld_t_q[0]); end
  endtask

  task automatic test_frame_err();
    int unsigned e0, e1;
    clear_mon();
    send_frame(8'h3C, 1'b0, e0);
    drive(40, 1'b0);
    n_cmp++; if (ferr_t_q.size() !== 1) begin n_bad++; $display("FAIL ferr_count: got %0d expected 1", ferr_t_q.size()); end
    n_cmp++; if (ferr_t_q[0] !== stop_edge(e0)) begin n_bad++; $display("FAIL ferr_time: got %0d expected %0d", ferr_t_q[0], stop_edge(e0)); end
    n_cmp++; if (vld_t_q.size() !== 0) begin n_bad++; $display("FAIL ferr_no_valid: got %0d pulses expected 0", vld_t_q.size()); end
    n_cmp++; if (DATA !== 8'hFF) begin n_bad++; $display("FAIL ferr_data_kept: got %0h expected ff", DATA); end
    n_cmp++; if (rise_q.size() !== 1) begin n_bad++; $display("FAIL ferr_break_retrigger: got %0d busy rises expected 1", rise_q.size()); end
    drive(20, 1'b1);
    clear_mon();
    send_frame(8'h81, 1'b1, e1);
    drive(10, 1'b1);
    n_cmp++; if (vld_t_q.size() !== 1 || vld_d_q[0] !== 8'h81) begin n_bad++; $display("FAIL ferr_recover: got %0d pulses data %0h expected 1 pulse data 81", vld_t_q.size(), vld_d_q[0]); end
  endtask

  task automatic test_glitch();
    int unsigned e0;
    clear_mon();
    e0 = cyc + 1;
    drive(4, 1'b0);
    drive(30, 1'b1);
    n_cmp++; if (rise_q.size() !== 1 || rise_q[0] !== e0 + 2) begin n_bad++; $display("FAIL glitch_busy_rise: got %0d expected %0d", rise_q[0], e0 + 2); end
    n_cmp++; if (fall_q.size() !== 1 || fall_q[0] !== e0 + 2 + HALF) begin n_bad++; $display("FAIL glitch_busy_fall: got %0d expected %0d", fall_q[0], e0 + 2 + HALF); end
    n_cmp++; if (vld_t_q.size() + ferr_t_q.size() !== 0) begin n_bad++; $display("FAIL glitch_pulses: got %0d expected 0", vld_t_q.size() + ferr_t_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [7:0]  b = 8'h55;
    int unsigned e1;
    clear_mon();
    drive(CPB, 1'b0);
    for (int i = 0; i < 3; i++) drive(CPB, b[i]);
    drive(HALF, b[3]);
    RST_N   = 1'b0;
    RX_LINE = 1'b1;
    #1;
    n_cmp++; if ({DATA, VALID, FRAME_ERR, BUSY} !== 11'd0) begin n_bad++; $display("FAIL midrst_outputs: got %0h expected 0", {DATA, VALID, FRAME_ERR, BUSY}); end
    repeat (3) @(negedge CLK);
    n_cmp++; if (DATA !== 8'h00 || BUSY !== 1'b0) begin n_bad++; $display("FAIL midrst_held: got data %0h busy %0b expected 0 0", DATA, BUSY); end
    RST_N = 1'b1;
    drive(200, 1'b1);
    n_cmp++; if (vld_t_q.size() + ferr_t_q.size() !== 0) begin n_bad++; $display("FAIL midrst_no_pulse: got %0d expected 0", vld_t_q.size() + ferr_t_q.size()); end
    clear_mon();
    send_frame(8'h81, 1'b1, e1);
    drive(10, 1'b1);
    n_cmp++; if (vld_t_q.size() !== 1 || vld_d_q[0] !== 8'h81 || vld_t_q[0] !== stop_edge(e1)) begin n_bad++; $display("FAIL midrst_next_frame: got %0d pulses data %0h t %0d expected 1 81 %0d", vld_t_q.size(), vld_d_q[0], vld_t_q[0], stop_edge(e1)); end
  endtask

  task automatic test_random();
    logic [7:0]  exp_q[$];
    int unsigned exp_t_q[$];
    logic [7:0]  b;
    int unsigned e0;
    int          gap;
    clear_mon();
    for (int n = 0; n < 200; n++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, e0);
      exp_q.push_back(b);
      exp_t_q.push_back(stop_edge(e0));
      gap = $urandom_range(0, 20);
      if (gap > 0) drive(gap, 1'b1);
    end
    drive(20, 1'b1);
    n_cmp++; if (vld_d_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d expected %0d", vld_d_q.size(), exp_q.size()); end
    n_cmp++; if (ferr_t_q.size() !== 0) begin n_bad++; $display("FAIL rand_ferr: got %0d expected 0", ferr_t_q.size()); end
    for (int i = 0; i < exp_q.size() && i < vld_d_q.size(); i++) begin
      n_cmp++; if (vld_d_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_data[%0d]: got %0h expected %0h", i, vld_d_q[i], exp_q[i]); end
      n_cmp++; if (vld_t_q[i] !== exp_t_q[i]) begin n_bad++; $display("FAIL rand_time[%0d]: got %0d expected %0d", i, vld_t_q[i], exp_t_q[i]); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    RST_N   = 1'b0;
    RX_LINE = 1'b1;
    @(negedge CLK);
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

- 8N1 UART receiver, LSB first. It is the receive-side counterpart of the team's `tx` transmitter.
- It oversamples `RX_LINE` with the system clock and checks each frame's start and stop bits.
- Each good byte is presented as a one-cycle `VALID` pulse with `DATA`.
- It sits between the board RX pin and the byte consumer (command parser / FIFO) on the 50 MHz fabric clock.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per bit (50 MHz / 9600 baud). Must be even and ≥ 4.
- `HALF_BIT` (localparam) = `CLKS_PER_BIT`/2: start-bit mid-point offset.
- `CLK` input 1: system clock; everything updates on the rising edge.
- `RST_N` input 1: reset, asynchronous and active-low.
- `RX_LINE` input 1: serial line, asynchronous to `CLK`, idles high.
- `DATA` output 8: last correctly received byte. Holds its value until the next good frame.
- `VALID` output 1: one-cycle pulse when `DATA` is updated.
- `FRAME_ERR` output 1: one-cycle pulse when the stop bit samples low. `DATA` is unchanged when it fires.
- `BUSY` output 1: high in any state other than IDLE.

## Operation
- **Reset values:** `DATA`=0, `VALID`=0, `FRAME_ERR`=0, `BUSY`=0; state IDLE.
- **Line synchronizer:** two flops plus a previous-value flop. All three reset to 1, so reset never produces a false start.
- **IDLE:** go to START when the synchronized line is 0 and the previous value is 1 (falling edge). Clear the counter.
- **START:** count up. At count `HALF_BIT`-1:
  - line 0 → DATA state; clear counter and bit index.
  - line 1 → glitch; return to IDLE with no output pulse.
- **DATA:** count to `CLKS_PER_BIT`-1, sample the line into shift-register bit [index], clear the counter, increment index. After index 7 is sampled, go to STOP.
- **STOP:** count to `CLKS_PER_BIT`-1, then sample the line and return to IDLE.
  - Sample 1 → load `DATA` from the shift register and pulse `VALID`.
  - Sample 0 → pulse `FRAME_ERR`.
- **Edge rule:** IDLE requires a falling edge. A line held low (break) after a frame error therefore never re-triggers until it returns high.
- **Back-to-back frames:** the return to IDLE at mid-stop-bit leaves half a bit for the next start edge.
- **No overrun handling:** `VALID` is not held. The consumer must capture `DATA` on the pulse.
- **Reset mid-frame:** the partial byte is discarded, no pulse is issued, and the block is in IDLE on the next edge after `RST_N` rises.
- **Counter widths:** counter is $clog2(`CLKS_PER_BIT`) bits and never exceeds `CLKS_PER_BIT`-1. Index is 3 bits.

## Timing
- Let edge 0 be the first `CLK` rising edge at which `RX_LINE` is low.
- Start edge is detected at edge 2, entering START with counter 0.
- Start verification happens at edge 2+`HALF_BIT`.
- Data bit n (n = 0..7) is sampled at edge 2+`HALF_BIT`+(n+1)·`CLKS_PER_BIT`.
- Stop bit is sampled at edge 2+`HALF_BIT`+9·`CLKS_PER_BIT`.
  - `VALID`/`FRAME_ERR` are high for exactly the cycle after that edge.
  - `DATA` changes on the same edge.
- `BUSY` rises after edge 2 and falls after the stop-sample edge, together with the pulse.
- Glitch rejection: a low pulse shorter than about `HALF_BIT`-2 cycles returns the block to IDLE at edge 2+`HALF_BIT`.

## Structure
- **Shared package `uart_pkg`:**
  - state enum {IDLE, START, DATA, STOP}, also to be adopted by a future FSM rewrite of `tx`;
  - `UART_DATA_W`=8;
  - default `CLKS_PER_BIT`=5208.
- **Sub-module `sync_2ff`:** generic 2-flop synchronizer with a reset-value parameter, instantiated with reset value 1. Reusable for other async inputs.
- **Kept inline:** the FSM, counter and shift register.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and `HALF_BIT`=8; the stop sample falls at edge 154.
- **Single frame:** drive 0xA5 (start, 1,0,1,0,0,1,0,1, stop). Expect `DATA`=0xA5, `VALID` high for the one cycle after edge 154, `FRAME_ERR`=0, `BUSY` high from after edge 2 to after edge 154.
- **Back-to-back:** send 0x00 then 0xFF, the second start driven immediately after the first stop bit ends. Expect two `VALID` pulses, 160 cycles apart, with `DATA` 0x00 then 0xFF.
- **Frame error:** send 0x3C with the stop bit driven 0 and the line held low for 40 cycles. Expect one `FRAME_ERR` pulse, no `VALID`, `DATA` unchanged, no new start detected until the line goes high and falls again.
- **Glitch:** drive a 4-cycle low pulse on an idle line. Expect `BUSY` high, then low after edge 10, and no `VALID` or `FRAME_ERR`.
- **Reset mid-frame:** assert `RST_N` low during data bit 3 of 0x55. Expect all outputs 0 while in reset. After release, expect no pulse, and a following 0x81 frame received correctly.
- **Random:** 200 random bytes with 0–20 idle cycles between frames, compared against a scoreboard. Expect zero mismatches and zero `FRAME_ERR`.
